tga_stream_decoder: RTL and testbench
=====================================

// Module: tga_stream_decoder
// PURPOSE
//  Inverse of the frame dumper: parses a byte stream holding a 24bpp truecolor .tga file.
//  Validates the 18-byte header, skips the image-ID field, then emits one write per pixel.
//  Each write carries a framebuffer address and an RGB value.
//  Feeds texture/framebuffer memory from file-backed or DMA byte sources.
// PARAMETERS
//  RES_X   320                    required image width, pixels
//  RES_Y   240                    required image height, pixels
//  ADDR_W  $clog2(RES_X*RES_Y)    pixel address width
// PORTS
//  clk       in   1       clock
//  rst       in   1       synchronous, active-high reset
//  s_valid   in   1       input byte valid
//  s_ready   out  1       input byte accepted when s_valid&&s_ready
//  s_data    in   8       file byte
//  s_last    in   1       marks final byte of file
//  px_valid  out  1       pixel write valid
//  px_ready  in   1       pixel write accepted when px_valid&&px_ready
//  px_addr   out  ADDR_W  y*RES_X + x, row-major, row 0 = top
//  px_data   out  24      {R,G,B}
//  done      out  1       1-cycle pulse after the s_last byte is accepted
//  error     out  1       frame rejected/truncated; held until first byte of next file accepted
//  err_code  out  3       0 none,1 bad type,2 colormap,3 depth,4 size,5 descriptor,6 truncated
// BEHAVIOUR
//  Reset: s_ready=0 during rst; all outputs=0; state=HDR; counters=0.
//  Mid-frame reset abandons the frame, with no done pulse.
//  States: HDR -> SKIP_ID -> PIX <-> EMIT -> DRAIN -> HDR; error paths go to DRAIN.
//  HDR: s_ready=1; latch bytes 0..17 little-endian.
//   Checks at byte 17, in priority order:
//    byte2!=2 -> 1; byte1!=0 -> 2; byte16!=24 -> 3;
//    width(b12,b13)!=RES_X or height(b14,b15)!=RES_Y -> 4;
//    b17[7:6]!=0 or b17[4]!=0 -> 5.
//  SKIP_ID: discard byte0 bytes; when byte0==0, go straight to PIX.
//  PIX: s_ready=1; collect B,G,R. The cycle after R is accepted, px_valid=1 (EMIT).
//  EMIT: s_ready=0; px_* held stable until px_ready; then advance x/y.
//  Origin: b17[5]=1 -> first row y=0, rows increment.
//          b17[5]=0 -> first row y=RES_Y-1, rows decrement.
//  x wraps RES_X-1 -> 0 with a row step. After pixel RES_X*RES_Y is accepted, go to DRAIN.
//  DRAIN: s_ready=1; discard trailing bytes (footer/extension) with no error.
//   On s_last: done=1 next cycle, then HDR.
//  s_last accepted in HDR/SKIP_ID/PIX before the final pixel:
//   error=1, err_code=6, done pulse, back to HDR; any partial pixel is dropped.
//  Header error: error/err_code set the cycle after byte 17; DRAIN until s_last, then done.
//  s_valid and px_ready arriving in the same cycle are independent; no byte is lost or duplicated.
//  Peak rate: 1 pixel per 4 cycles (3 bytes + 1 emit) with px_ready held high.
// CONFIGURATION
//  TGA_RLE_EN defined:
//   Also accept type 10 (RLE truecolor). PIX begins each packet with a packet byte.
//   bit7=1: run of (b[6:0]+1) copies of the next pixel. EMIT repeats at 1 pixel/cycle, s_ready=0.
//   bit7=0: raw packet of (b[6:0]+1) pixels, each behaves as in non-RLE PIX.
//   A packet that overruns RES_X*RES_Y: write the in-range pixels, discard the rest, set err_code=6.
//   Runs span row boundaries.
//  TGA_RLE_EN undefined: type 10 -> err_code=1; RLE logic absent.
// TESTING
//  2x2 top-left raw (b17=0x20), pixels 0x0000FF..: addrs 0,1,2,3; first px_data=24'hFF0000; done after s_last.
//  Same image, b17=0x00: addr order 2,3,0,1 for RES_X=RES_Y=2.
//  byte0=5 ID field plus a 26-byte footer: ID skipped, 4 writes, footer drained, error=0.
//  px_ready low 10 cycles on the 2nd pixel: px_addr/px_data stable, s_ready=0, no byte lost.
//  depth=32 -> err_code=3 after byte17. s_last after 7 pixel bytes -> err_code=6, done=1.
//  [TGA_RLE_EN] type 10, packet 0x83 + 0x102030: 4 writes of 24'h302010 on consecutive cycles.

Source files
------------

// File: rtl/tga_stream_decoder.sv
// tga_stream_decoder: parses a 24bpp truecolor TGA byte stream into per-pixel framebuffer writes.
// Define TGA_RLE_EN to also accept RLE truecolor (image type 10).
module tga_stream_decoder #(
  parameter int RES_X  = 320,
  parameter int RES_Y  = 240,
  parameter int ADDR_W = $clog2(RES_X*RES_Y)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [ADDR_W-1:0] px_addr,
  output logic [23:0]       px_data,
  output logic              done,
  output logic              error,
  output logic [2:0]        err_code
);
  typedef enum logic [2:0] {HDR, SKIP_ID, PIX, EMIT, DRAIN} state_t;

  localparam logic [2:0]        ERR_TRUNC = 3'd6;
  localparam logic [15:0]       W16       = 16'(RES_X);
  localparam logic [15:0]       H16       = 16'(RES_Y);
  localparam logic [ADDR_W-1:0] X_MAX     = ADDR_W'(RES_X-1);
  localparam logic [ADDR_W-1:0] Y_MAX     = ADDR_W'(RES_Y-1);
  localparam logic [ADDR_W-1:0] LAST_PX   = ADDR_W'(RES_X*RES_Y-1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_t            state, state_n;
  logic [4:0]        hdr_cnt;
  logic [7:0]        id_len, id_cnt, cmap_type, img_type, depth;
  logic [15:0]       width, height;
  logic              top_origin;
  logic [1:0]        phase;
  logic [7:0]        b_q, g_q;
  logic [ADDR_W-1:0] x, y, pix_cnt;
  logic              last_pend;
  logic [2:0]        hdr_code;
  logic              type_ok, final_px, pkt_hdr_byte, overrun, run_more;
  logic              err_set, end_file;
  logic [2:0]        err_val;

`ifdef TGA_RLE_EN
  logic       rle_mode, pkt_run;
  logic [7:0] pkt_rem;

  assign type_ok      = (img_type == 8'd2) || (img_type == 8'd10);
  assign pkt_hdr_byte = rle_mode && (pkt_rem == '0);
  assign overrun      = rle_mode && (pkt_rem > 8'd1);
  assign run_more     = overrun && pkt_run;

  // pkt_rem counts pixels still owed by the current packet, including the one being emitted
  always_ff @(posedge clk) begin
    if (rst) begin
      rle_mode <= 1'b0;
      pkt_run  <= 1'b0;
      pkt_rem  <= '0;
    end else if (state == HDR && s_valid && hdr_cnt == 5'd17) begin
      rle_mode <= (img_type == 8'd10);
      pkt_rem  <= '0;
    end else if (state == PIX && s_valid && pkt_hdr_byte) begin
      pkt_rem  <= {1'b0, s_data[6:0]} + 8'd1;
      pkt_run  <= s_data[7];
    end else if (state == EMIT && px_ready && rle_mode) begin
      pkt_rem  <= pkt_rem - 8'd1;
    end
  end
`else
  assign type_ok      = (img_type == 8'd2);
  assign pkt_hdr_byte = 1'b0;
  assign overrun      = 1'b0;
  assign run_more     = 1'b0;
`endif

  assign final_px = (pix_cnt == LAST_PX);
  assign px_addr  = ADDR_W'(int'(y) * RES_X + int'(x));

  always_comb begin
    hdr_code = 3'd0;
    if (!type_ok)                                 hdr_code = 3'd1;
    else if (cmap_type != 8'd0)                   hdr_code = 3'd2;
    else if (depth != 8'd24)                      hdr_code = 3'd3;
    else if (width != W16 || height != H16)       hdr_code = 3'd4;
    else if (s_data[7:6] != 2'b00 || s_data[4])   hdr_code = 3'd5;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= HDR;
    else     state <= state_n;
  end

  // An R byte carrying s_last still emits its pixel; truncation is judged after that write
  always_comb begin
    state_n  = state;
    s_ready  = 1'b0;
    px_valid = 1'b0;
    err_set  = 1'b0;
    err_val  = '0;
    end_file = 1'b0;
    case (state)
      HDR: begin
        s_ready = !rst;
        if (s_valid) begin
          if (hdr_cnt == 5'd17 && hdr_code != 3'd0) begin
            err_set  = 1'b1;
            err_val  = hdr_code;
            end_file = s_last;
            state_n  = s_last ? HDR : DRAIN;
          end else if (s_last) begin
            err_set  = 1'b1;
            err_val  = ERR_TRUNC;
            end_file = 1'b1;
          end else if (hdr_cnt == 5'd17) begin
            state_n  = (id_len == 8'd0) ? PIX : SKIP_ID;
          end
        end
      end
      SKIP_ID: begin
        s_ready = !rst;
        if (s_valid) begin
          if (s_last) begin
            err_set  = 1'b1;
            err_val  = ERR_TRUNC;
            end_file = 1'b1;
            state_n  = HDR;
          end else if (id_cnt == id_len - 8'd1) begin
            state_n  = PIX;
          end
        end
      end
      PIX: begin
        s_ready = !rst;
        if (s_valid) begin
          if (!pkt_hdr_byte && phase == 2'd2) begin
            state_n  = EMIT;
          end else if (s_last) begin
            err_set  = 1'b1;
            err_val  = ERR_TRUNC;
            end_file = 1'b1;
            state_n  = HDR;
          end
        end
      end
      EMIT: begin
        px_valid = 1'b1;
        if (px_ready) begin
          if (final_px) begin
            err_set  = overrun;
            err_val  = overrun ? ERR_TRUNC : 3'd0;
            end_file = last_pend;
            state_n  = last_pend ? HDR : DRAIN;
          end else if (run_more) begin
            state_n  = EMIT;
          end else if (last_pend) begin
            err_set  = 1'b1;
            err_val  = ERR_TRUNC;
            end_file = 1'b1;
            state_n  = HDR;
          end else begin
            state_n  = PIX;
          end
        end
      end
      DRAIN: begin
        s_ready = !rst;
        if (s_valid && s_last) begin
          end_file = 1'b1;
          state_n  = HDR;
        end
      end
      default: state_n = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_cnt    <= '0;
      id_len     <= '0;
      id_cnt     <= '0;
      cmap_type  <= '0;
      img_type   <= '0;
      depth      <= '0;
      width      <= '0;
      height     <= '0;
      top_origin <= 1'b0;
      phase      <= '0;
      b_q        <= '0;
      g_q        <= '0;
      x          <= '0;
      y          <= '0;
      pix_cnt    <= '0;
      last_pend  <= 1'b0;
      px_data    <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= '0;
    end else begin
      done <= end_file;
      if (err_set) begin
        error    <= 1'b1;
        err_code <= err_val;
      end else if (state == HDR && s_valid && hdr_cnt == 5'd0) begin
        error    <= 1'b0;
        err_code <= '0;
      end
      case (state)
        HDR: if (s_valid) begin
          hdr_cnt <= (hdr_cnt == 5'd17 || s_last) ? '0 : hdr_cnt + 5'd1;
          case (hdr_cnt)
            5'd0:  id_len        <= s_data;
            5'd1:  cmap_type     <= s_data;
            5'd2:  img_type      <= s_data;
            5'd12: width[7:0]    <= s_data;
            5'd13: width[15:8]   <= s_data;
            5'd14: height[7:0]   <= s_data;
            5'd15: height[15:8]  <= s_data;
            5'd16: depth         <= s_data;
            5'd17: begin
              top_origin <= s_data[5];
              x          <= '0;
              y          <= s_data[5] ? '0 : Y_MAX;
              pix_cnt    <= '0;
              phase      <= '0;
              id_cnt     <= '0;
              last_pend  <= 1'b0;
            end
            default: ;
          endcase
        end
        SKIP_ID: if (s_valid) id_cnt <= id_cnt + 8'd1;
        PIX: if (s_valid && !pkt_hdr_byte) begin
          case (phase)
            2'd0: begin
              b_q   <= s_data;
              phase <= 2'd1;
            end
            2'd1: begin
              g_q   <= s_data;
              phase <= 2'd2;
            end
            default: begin
              px_data   <= {s_data, g_q, b_q};
              phase     <= 2'd0;
              last_pend <= s_last;
            end
          endcase
        end
        EMIT: if (px_ready) begin
          pix_cnt <= pix_cnt + ONE;
          if (x == X_MAX) begin
            x <= '0;
            y <= top_origin ? y + ONE : y - ONE;
          end else begin
            x <= x + ONE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tga_stream_decoder.sv
// Randomized self-checking bench for tga_stream_decoder against a file-level TGA parsing model.
// Honours TGA_RLE_EN the same way the design does.
module tb_tga_stream_decoder;
  localparam int RES_X  = 3;
  localparam int RES_Y  = 2;
  localparam int NPIX   = RES_X * RES_Y;
  localparam int AW     = $clog2(NPIX);
  localparam int BUDGET = 3000;
`ifdef TGA_RLE_EN
  localparam bit RLE = 1'b1;
`else
  localparam bit RLE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = '0;
  logic          s_last = 1'b0;
  logic          px_valid;
  logic          px_ready = 1'b0;
  logic [AW-1:0] px_addr;
  logic [23:0]   px_data;
  logic          done;
  logic          error;
  logic [2:0]    err_code;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  fbytes[$];
  int          exp_addr[$];
  logic [23:0] exp_data[$];
  int          exp_code, exp_hc;
  bit          prev_err = 1'b0;
  logic [23:0] first_data;
  int          nwrites;

  always #5 clk = ~clk;

  tga_stream_decoder #(.RES_X(RES_X), .RES_Y(RES_Y)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .px_valid(px_valid), .px_ready(px_ready), .px_addr(px_addr), .px_data(px_data),
    .done(done), .error(error), .err_code(err_code)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int addr_of(input int i, input bit top);
    int r;
    r = i / RES_X;
    return (top ? r : RES_Y - 1 - r) * RES_X + i % RES_X;
  endfunction

  task automatic gen_file(input int ty, input int cm, input int dep, input int wv, input int hv,
                          input int desc, input int idl, input int ftr);
    int cnt;
    fbytes.delete();
    fbytes.push_back(8'(idl));
    fbytes.push_back(8'(cm));
    fbytes.push_back(8'(ty));
    repeat (9) fbytes.push_back(8'h00);
    fbytes.push_back(8'(wv));
    fbytes.push_back(8'(wv >> 8));
    fbytes.push_back(8'(hv));
    fbytes.push_back(8'(hv >> 8));
    fbytes.push_back(8'(dep));
    fbytes.push_back(8'(desc));
    repeat (idl) fbytes.push_back(8'($urandom));
    if (ty == 10) begin
      cnt = 0;
      while (cnt < NPIX) begin
        int len;
        bit run;
        len = $urandom_range(1, 4);
        run = 1'($urandom_range(1));
        fbytes.push_back({run, 7'(len - 1)});
        if (run) repeat (3) fbytes.push_back(8'($urandom));
        else     repeat (3 * len) fbytes.push_back(8'($urandom));
        cnt += len;
      end
    end else begin
      repeat (3 * NPIX) fbytes.push_back(8'($urandom));
    end
    repeat (ftr) fbytes.push_back(8'($urandom));
  endtask

  // Expected writes and final error code, derived from the file bytes alone
  task automatic model_file();
    int n, pos, cnt, avail;
    bit top;
    logic [7:0] h[18];
    logic [23:0] px;
    n = fbytes.size();
    exp_addr.delete();
    exp_data.delete();
    exp_code = 0;
    exp_hc = 0;
    if (n < 18) begin
      exp_code = 6;
      return;
    end
    for (int i = 0; i < 18; i++) h[i] = fbytes[i];
    if (!(h[2] == 8'd2 || (RLE && h[2] == 8'd10)))                 exp_hc = 1;
    else if (h[1] != 8'd0)                                          exp_hc = 2;
    else if (h[16] != 8'd24)                                        exp_hc = 3;
    else if ({h[13], h[12]} != 16'(RES_X) || {h[15], h[14]} != 16'(RES_Y)) exp_hc = 4;
    else if (h[17][7:6] != 2'b00 || h[17][4])                       exp_hc = 5;
    if (exp_hc != 0) begin
      exp_code = exp_hc;
      return;
    end
    top = h[17][5];
    pos = 18 + int'(h[0]);
    if (pos >= n) begin
      exp_code = 6;
      return;
    end
    cnt = 0;
    if (h[2] == 8'd10) begin
      while (cnt < NPIX && exp_code == 0) begin
        logic [7:0] ph;
        int len;
        if (pos >= n) begin
          exp_code = 6;
          break;
        end
        ph = fbytes[pos];
        pos++;
        len = int'(ph[6:0]) + 1;
        if (ph[7]) begin
          if (pos + 3 > n) begin
            exp_code = 6;
            break;
          end
          px = {fbytes[pos+2], fbytes[pos+1], fbytes[pos]};
          pos += 3;
          for (int r = 0; r < len; r++) begin
            if (cnt >= NPIX) begin
              exp_code = 6;
              break;
            end
            exp_addr.push_back(addr_of(cnt, top));
            exp_data.push_back(px);
            cnt++;
          end
        end else begin
          for (int r = 0; r < len; r++) begin
            if (cnt >= NPIX || pos + 3 > n) begin
              exp_code = 6;
              break;
            end
            exp_addr.push_back(addr_of(cnt, top));
            exp_data.push_back({fbytes[pos+2], fbytes[pos+1], fbytes[pos]});
            pos += 3;
            cnt++;
          end
        end
      end
    end else begin
      avail = (n - pos) / 3;
      while (cnt < NPIX && cnt < avail) begin
        exp_addr.push_back(addr_of(cnt, top));
        exp_data.push_back({fbytes[pos+2], fbytes[pos+1], fbytes[pos]});
        pos += 3;
        cnt++;
      end
      if (cnt < NPIX) exp_code = 6;
    end
  endtask

  task automatic run_file(input int stall_px, input int vprob, input int rprob);
    int bi, cyc, dones, wi, stall, after, ea;
    bit pv_prev, chk17;
    logic [AW-1:0] pa;
    logic [23:0] pd, ed;
    bi = 0; cyc = 0; dones = 0; wi = 0; stall = 0; after = 0;
    pv_prev = 1'b0; chk17 = 1'b0; pa = '0; pd = '0;
    first_data = '0;
    model_file();
    check_eq("err_hold", {31'd0, error}, {31'd0, prev_err});
    while (cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (chk17) begin
        check_eq("hdr_err", {31'd0, error}, 32'd1);
        check_eq("hdr_code", {29'd0, err_code}, exp_hc);
        chk17 = 1'b0;
      end
      if (done) dones++;
      if (dones > 0 && bi >= fbytes.size()) after++;
      if (after >= 3) break;
      if (px_valid) begin
        check_eq("s_ready_emit", {31'd0, s_ready}, 32'd0);
        if (pv_prev) begin
          check_eq("hold_addr", {{(32-AW){1'b0}}, px_addr}, {{(32-AW){1'b0}}, pa});
          check_eq("hold_data", {8'd0, px_data}, {8'd0, pd});
        end
      end
      if (bi < fbytes.size()) begin
        s_valid = ($urandom_range(99) < vprob);
        s_data  = fbytes[bi];
        s_last  = (bi == fbytes.size() - 1);
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      if (px_valid && wi == stall_px && stall < 10) begin
        px_ready = 1'b0;
        stall++;
      end else begin
        px_ready = ($urandom_range(99) < rprob);
      end
      if (s_valid && s_ready) begin
        if (bi == 17 && exp_hc != 0) chk17 = 1'b1;
        bi++;
      end
      if (px_valid && px_ready) begin
        if (wi == 0) first_data = px_data;
        if (exp_addr.size() == 0) begin
          check_eq("extra_write", 32'd1, 32'd0);
        end else begin
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          check_eq("px_addr", {{(32-AW){1'b0}}, px_addr}, ea);
          check_eq("px_data", {8'd0, px_data}, {8'd0, ed});
        end
        wi++;
        pv_prev = 1'b0;
      end else if (px_valid) begin
        pv_prev = 1'b1;
        pa = px_addr;
        pd = px_data;
      end else begin
        pv_prev = 1'b0;
      end
    end
    s_valid  = 1'b0;
    s_last   = 1'b0;
    px_ready = 1'b0;
    if (cyc >= BUDGET) check_eq("timeout", 32'd1, 32'd0);
    nwrites = wi;
    check_eq("writes_left", exp_addr.size(), 32'd0);
    check_eq("done_pulses", dones, 32'd1);
    check_eq("error", {31'd0, error}, (exp_code != 0) ? 32'd1 : 32'd0);
    check_eq("err_code", {29'd0, err_code}, exp_code);
    prev_err = (exp_code != 0);
  endtask

  initial begin
    s_valid = 1'b1;
    s_data  = 8'hAA;
    repeat (3) @(negedge clk);
    check_eq("rst_s_ready",  {31'd0, s_ready}, 32'd0);
    check_eq("rst_px_valid", {31'd0, px_valid}, 32'd0);
    check_eq("rst_done",     {31'd0, done}, 32'd0);
    check_eq("rst_error",    {31'd0, error}, 32'd0);
    check_eq("rst_err_code", {29'd0, err_code}, 32'd0);
    check_eq("rst_px_addr",  {{(32-AW){1'b0}}, px_addr}, 32'd0);
    check_eq("rst_px_data",  {8'd0, px_data}, 32'd0);
    s_valid = 1'b0;
    rst = 1'b0;

    gen_file(2, 0, 24, RES_X, RES_Y, 8'h20, 0, 0);
    fbytes[18] = 8'h00; fbytes[19] = 8'h00; fbytes[20] = 8'hFF;
    run_file(-1, 100, 100);
    check_eq("first_data", {8'd0, first_data}, 32'h00FF0000);
    check_eq("nwrites_tl", nwrites, NPIX);

    gen_file(2, 0, 24, RES_X, RES_Y, 8'h00, 0, 0);
    run_file(-1, 100, 100);

    gen_file(2, 0, 24, RES_X, RES_Y, 8'h20, 5, 26);
    run_file(-1, 100, 100);
    check_eq("nwrites_id", nwrites, NPIX);
    check_eq("footer_err", {31'd0, error}, 32'd0);

    gen_file(2, 0, 24, RES_X, RES_Y, 8'h20, 0, 2);
    run_file(1, 100, 100);

    gen_file(2, 0, 32, RES_X, RES_Y, 8'h20, 0, 4);
    run_file(-1, 100, 100);
    check_eq("depth_code", {29'd0, err_code}, 32'd3);

    gen_file(2, 0, 24, RES_X, RES_Y, 8'h20, 0, 0);
    while (fbytes.size() > 25) void'(fbytes.pop_back());
    run_file(-1, 100, 100);
    check_eq("trunc_code", {29'd0, err_code}, 32'd6);
    check_eq("trunc_writes", nwrites, 32'd2);

`ifdef TGA_RLE_EN
    gen_file(10, 0, 24, RES_X, RES_Y, 8'h20, 0, 0);
    while (fbytes.size() > 18) void'(fbytes.pop_back());
    fbytes.push_back(8'h83);
    fbytes.push_back(8'h10); fbytes.push_back(8'h20); fbytes.push_back(8'h30);
    fbytes.push_back(8'h01);
    repeat (6) fbytes.push_back(8'($urandom));
    run_file(-1, 100, 100);
    check_eq("rle_first", {8'd0, first_data}, 32'h00302010);
`else
    gen_file(10, 0, 24, RES_X, RES_Y, 8'h20, 0, 0);
    run_file(-1, 100, 100);
    check_eq("type10_code", {29'd0, err_code}, 32'd1);
`endif

    gen_file(3, 0, 24, RES_X, RES_Y, 8'h20, 0, 1);          run_file(-1, 100, 100);
    gen_file(2, 1, 24, RES_X, RES_Y, 8'h20, 0, 1);          run_file(-1, 100, 100);
    gen_file(2, 0, 24, RES_X + 1, RES_Y, 8'h20, 0, 1);      run_file(-1, 100, 100);
    gen_file(2, 0, 24, RES_X, RES_Y + 256, 8'h20, 0, 1);    run_file(-1, 100, 100);
    gen_file(2, 0, 24, RES_X, RES_Y, 8'h30, 0, 1);          run_file(-1, 100, 100);
    gen_file(2, 0, 24, RES_X, RES_Y, 8'h80, 0, 1);          run_file(-1, 100, 100);

    gen_file(2, 0, 24, RES_X, RES_Y, 8'h20, 0, 0);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = fbytes[i];
      px_ready = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    px_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("mid_rst_px_valid", {31'd0, px_valid}, 32'd0);
      check_eq("mid_rst_done", {31'd0, done}, 32'd0);
      check_eq("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
    end
    rst = 1'b0;
    prev_err = 1'b0;
    gen_file(2, 0, 24, RES_X, RES_Y, 8'h00, 1, 1);
    run_file(-1, 100, 100);

    for (int t = 0; t < 40; t++) begin
      int ty, cm, dep, wv, hv, desc, r, cut;
      ty = (RLE && $urandom_range(1) == 1) ? 10 : 2;
      cm = 0; dep = 24; wv = RES_X; hv = RES_Y;
      desc = int'($urandom_range(1) << 5) | int'($urandom_range(15));
      r = $urandom_range(9);
      case (r)
        0: ty = 3;
        1: cm = 1;
        2: dep = 32;
        3: wv = RES_X + 1;
        4: desc = desc | 8'h10;
        default: ;
      endcase
      gen_file(ty, cm, dep, wv, hv, desc, $urandom_range(3), $urandom_range(4));
      if ($urandom_range(4) == 0) begin
        cut = $urandom_range(1, fbytes.size());
        while (fbytes.size() > cut) void'(fbytes.pop_back());
      end
      run_file(($urandom_range(3) == 0) ? int'($urandom_range(NPIX - 1)) : -1,
               $urandom_range(40, 100), $urandom_range(30, 100));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
